// File: rtl/fadd_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : fadd_wb_queue
// Purpose  : FIFO between the FP adder and the FP register-file writeback
//            port. Keeps sticky {ovf, nan, zero} status flags.
// Revision : 1.0
// ============================================================================
module fadd_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int RD_W  = 5
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_y,
    input  logic            in_ovf,
    input  logic [RD_W-1:0] in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_data,
    output logic [RD_W-1:0] out_rd,
    input  logic            flush,
    input  logic            fflags_clr,
    output logic [2:0]      fflags,
    output logic [AW:0]     count
);

    localparam logic [AW:0] c_full = DEPTH[AW:0];

    logic [31:0]     r_y_mem  [DEPTH];
    logic [RD_W-1:0] r_rd_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic [2:0]      r_fflags;

    logic            w_push;
    logic            w_pop;
    logic            w_nan;
    logic            w_zero;
    logic [2:0]      w_event;
    logic [2:0]      w_fflags_next;

    // Ready comes from the registered count only, so a full queue refuses a
    // push even when the head is being popped in the same cycle.
    assign in_ready  = (r_count != c_full);
    assign out_valid = (r_count != '0);
    assign out_data  = r_y_mem[r_rd_ptr];
    assign out_rd    = r_rd_mem[r_rd_ptr];
    assign count     = r_count;
    assign fflags    = r_fflags;

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    assign w_nan   = (in_y[30:23] == 8'hFF) && (in_y[22:0] != 23'd0);
    assign w_zero  = (in_y[30:0] == 31'd0);
    assign w_event = {in_ovf, w_nan, w_zero};

    // A set in the same cycle as a clear wins; a flushed push sets nothing.
    always_comb begin
        w_fflags_next = fflags_clr ? 3'b000 : r_fflags;
        if (w_push && !flush) begin
            w_fflags_next = w_fflags_next | w_event;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_y_mem[i]  <= '0;
                r_rd_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_y_mem[r_wr_ptr]  <= in_y;
                r_rd_mem[r_wr_ptr] <= in_rd;
                r_wr_ptr           <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_fflags <= 3'b000;
        end else begin
            r_fflags <= w_fflags_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fadd_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fadd_wb_queue
// Purpose  : Directed plus randomized bench for fadd_wb_queue against a
//            queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_fadd_wb_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int RD_W  = 5;

    logic            clk = 1'b0;
    logic            rstn;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_y;
    logic            in_ovf;
    logic [RD_W-1:0] in_rd;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_data;
    logic [RD_W-1:0] out_rd;
    logic            flush;
    logic            fflags_clr;
    logic [2:0]      fflags;
    logic [AW:0]     count;

    fadd_wb_queue #(.DEPTH(DEPTH), .AW(AW), .RD_W(RD_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_y       (in_y),
        .in_ovf     (in_ovf),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_rd     (out_rd),
        .flush      (flush),
        .fflags_clr (fflags_clr),
        .fflags     (fflags),
        .count      (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     y;
        logic [RD_W-1:0] rd;
    } ent_t;

    ent_t       mq[$];
    logic [2:0] mflags;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] flag_event(input logic [31:0] y, input logic ovf);
        int unsigned e, m;
        e = (y >> 23) & 32'hFF;
        m = y & 32'h7FFFFF;
        return {ovf, (e == 255) && (m != 0), (y & 32'h7FFFFFFF) == 0};
    endfunction

    // Compare the current state against the model, clock once, advance the model.
    task automatic cycle();
        bit         ready, valid, push, pop;
        logic [2:0] f;
        ready = (mq.size() < DEPTH);
        valid = (mq.size() != 0);
        chk("in_ready", in_ready, ready);
        chk("out_valid", out_valid, valid);
        chk("count", count, 64'(mq.size()));
        chk("fflags", fflags, mflags);
        if (valid) begin
            chk("out_data", out_data, mq[0].y);
            chk("out_rd", out_rd, mq[0].rd);
        end
        @(posedge clk);
        #1;
        if (!rstn) begin
            mq.delete();
            mflags = 3'b000;
        end else if (flush) begin
            mq.delete();
            if (fflags_clr) mflags = 3'b000;
        end else begin
            push = in_valid && ready;
            pop  = valid && out_ready;
            f = fflags_clr ? 3'b000 : mflags;
            if (push) f = f | flag_event(in_y, in_ovf);
            mflags = f;
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back('{y: in_y, rd: in_rd});
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] y, input logic ovf,
                         input logic [RD_W-1:0] rd, input logic ordy);
        in_valid  = v;
        in_y      = y;
        in_ovf    = ovf;
        in_rd     = rd;
        out_ready = ordy;
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; fflags_clr = 1'b0;
        drive(1'b0, 32'd0, 1'b0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        mq.delete();
        mflags = 3'b000;
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_count", count, 0);
        chk("rst_in_ready", in_ready, 1);
        rstn = 1'b1;

        // Single push, one-cycle latency, then pop.
        drive(1'b1, 32'h3F80_0000, 1'b0, 5'd3, 1'b0);
        chk("t1_valid_push_cycle", out_valid, 0);
        cycle();
        drive(1'b0, 32'd0, 1'b0, '0, 1'b1);
        chk("t1_out_data", out_data, 32'h3F80_0000);
        chk("t1_out_rd", out_rd, 3);
        chk("t1_count", count, 1);
        cycle();
        chk("t1_count_after_pop", count, 0);
        drive(1'b0, 32'd0, 1'b0, '0, 1'b0);
        cycle();

        // Fill to full, refused 5th push, drain in order.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 32'(i), 1'b0, 5'(i), 1'b0);
            cycle();
        end
        chk("t2_full_count", count, 4);
        chk("t2_full_ready", in_ready, 0);
        drive(1'b1, 32'd5, 1'b0, 5'd5, 1'b0);
        cycle();
        chk("t2_refused_count", count, 4);
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 32'd0, 1'b0, '0, 1'b1);
            chk("t2_drain_data", out_data, 32'(i));
            cycle();
            if (i == 1) chk("t2_ready_after_pop", in_ready, 1);
        end
        chk("t2_empty_valid", out_valid, 0);

        // Full with simultaneous push and pop: only the pop happens.
        for (int i = 5; i <= 8; i++) begin
            drive(1'b1, 32'(i), 1'b0, 5'(i), 1'b0);
            cycle();
        end
        drive(1'b1, 32'd9, 1'b0, 5'd9, 1'b1);
        cycle();
        chk("t3_count_after_pop", count, 3);
        drive(1'b1, 32'd9, 1'b0, 5'd9, 1'b0);
        cycle();
        chk("t3_count_after_push", count, 4);
        drive(1'b0, 32'd0, 1'b0, '0, 1'b1);
        repeat (5) cycle();

        // Sticky flag sequence.
        drive(1'b1, 32'h7F80_0000, 1'b1, 5'd1, 1'b1);
        cycle();
        chk("f_ovf", fflags, 3'b100);
        drive(1'b1, 32'h7FC0_0000, 1'b0, 5'd2, 1'b1);
        cycle();
        chk("f_nan", fflags, 3'b110);
        drive(1'b1, 32'h8000_0000, 1'b0, 5'd3, 1'b1);
        cycle();
        chk("f_negzero", fflags, 3'b111);
        fflags_clr = 1'b1;
        drive(1'b1, 32'h0000_0000, 1'b0, 5'd4, 1'b1);
        cycle();
        chk("f_clr_and_set", fflags, 3'b001);
        drive(1'b0, 32'd0, 1'b0, '0, 1'b1);
        cycle();
        chk("f_clr", fflags, 3'b000);
        fflags_clr = 1'b0;
        repeat (2) cycle();

        // Steady push+pop at count 2 across the pointer wrap.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h100 + 32'(i), 1'b0, 5'(i), 1'b0);
            cycle();
        end
        for (int i = 2; i < 12; i++) begin
            drive(1'b1, 32'h100 + 32'(i), 1'b0, 5'(i), 1'b1);
            chk("wrap_data", out_data, 32'h100 + 32'(i - 2));
            cycle();
            chk("wrap_count", count, 2);
        end
        drive(1'b0, 32'd0, 1'b0, '0, 1'b1);
        repeat (3) cycle();

        // Flush with a flag-setting push in the same cycle.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h4000_0000 + 32'(i), 1'b0, 5'(i), 1'b0);
            cycle();
        end
        chk("fl_pre_count", count, 3);
        flush = 1'b1;
        drive(1'b1, 32'h7F80_0000, 1'b1, 5'd7, 1'b0);
        cycle();
        flush = 1'b0;
        drive(1'b0, 32'd0, 1'b0, '0, 1'b0);
        chk("fl_count", count, 0);
        chk("fl_valid", out_valid, 0);
        chk("fl_fflags", fflags, 3'b000);
        chk("fl_ready", in_ready, 1);
        cycle();

        // Randomized traffic including flush, clear and mid-traffic reset.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] y;
            case ($urandom_range(0, 5))
                0:       y = 32'h0000_0000;
                1:       y = 32'h8000_0000;
                2:       y = 32'h7F80_0000;
                3:       y = 32'hFF80_0001 + ($urandom & 32'h7_FFFF);
                default: y = $urandom;
            endcase
            drive(1'($urandom_range(0, 3) != 0), y, 1'($urandom_range(0, 7) == 0),
                  5'($urandom), 1'($urandom_range(0, 2) != 0));
            flush      = ($urandom_range(0, 29) == 0);
            fflags_clr = ($urandom_range(0, 19) == 0);
            rstn       = ($urandom_range(0, 59) != 0);
            cycle();
        end
        rstn = 1'b1; flush = 1'b0; fflags_clr = 1'b0;
        drive(1'b0, 32'd0, 1'b0, '0, 1'b1);
        repeat (5) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fadd_wb_queue.md
Name: fadd_wb_queue

Overview:
- Result-side buffer directly downstream of the combinational single-precision adder.
- Captures each adder result (y, ovf) with its destination register tag in a small FIFO.
- Hands results to the FP register-file writeback port with a valid/ready handshake.
- Keeps sticky floating-point status flags (overflow, NaN result, exact zero) for the core's CSR path.

Parameters:
DEPTH, 4, number of FIFO entries (power of two, >=2)
AW, 2, pointer width = log2(DEPTH)
RD_W, 5, destination register tag width

Ports:
clk  in  1  core clock
rstn  in  1  synchronous active-low reset
in_valid  in  1  adder result presented this cycle
in_ready  out  1  queue can accept a result
in_y  in  32  adder result word
in_ovf  in  1  adder overflow flag
in_rd  in  RD_W  destination FP register tag
out_valid  out  1  head entry available
out_ready  in  1  writeback port consumes head this cycle
out_data  out  32  head result word
out_rd  out  RD_W  head destination tag
flush  in  1  discard all queued entries (pipeline kill)
fflags_clr  in  1  clear sticky flags
fflags  out  3  sticky {ovf, nan, zero}
count  out  AW+1  number of valid entries

Behaviour:
- Reset (rstn=0 at posedge clk): wr_ptr, rd_ptr and count go to 0; all storage entries go to 0; fflags=3'b000; out_valid=0; out_data=0; out_rd=0; in_ready=1.
- Storage: DEPTH entries of {y, rd}. Sticky status is folded into fflags at push time, so ovf is not stored.
- in_ready = (count != DEPTH). It is decoded from the registered count only and never depends on out_ready in the same cycle.
- push = in_valid & in_ready. The entry is written at wr_ptr and wr_ptr increments modulo DEPTH (natural wrap at AW bits).
- pop = out_valid & out_ready. rd_ptr increments modulo DEPTH.
- out_valid = (count != 0). out_data and out_rd show the entry at rd_ptr combinationally from storage. There is no input-to-output bypass: a push into an empty queue gives out_valid=1 on the next cycle, so latency is 1 cycle.
- Count update:
  - push and pop in the same cycle: count is unchanged and both pointers advance.
  - push only: count+1.
  - pop only: count-1.
  - Full queue with in_valid=1 and out_ready=1: the pop happens, but the push is refused because in_ready=0 in that cycle. The producer must hold its data.
  - out_ready with an empty queue: ignored.
- Flush (synchronous, priority over push and pop): wr_ptr, rd_ptr and count go to 0. Storage is not cleared. The push in the flush cycle is dropped and does not update fflags. Existing fflags are kept.
- Sticky flags are evaluated only on an accepted push (not during flush):
  - fflags[2] |= in_ovf.
  - fflags[1] |= (in_y[30:23]==8'hFF && in_y[22:0]!=0).
  - fflags[0] |= (in_y[30:0]==0), which covers both +0 and -0.
- fflags_clr clears all three flags. If fflags_clr and a flag-setting push occur in the same cycle, the set wins: the result is the new event bits only.
- Reset in the middle of traffic discards all entries. A push or pop in the reset cycle has no effect.
- The queue never drops or duplicates an accepted entry. FIFO order is strict.

Test Plan:
- Reset, then a single push of y=32'h3F800000, rd=5'd3. Required: in_ready=1 throughout; out_valid=0 in the push cycle and 1 in the next cycle with out_data=32'h3F800000 and out_rd=3; count=1; fflags=000. Then pop, and count returns to 0.
- Push 4 entries y=1,2,3,4 with out_ready=0. Required: count=4 and in_ready=0. A 5th in_valid with y=5 is not accepted. Drain with out_ready=1 and check outputs 1,2,3,4 in order, in_ready=1 after the first pop, and out_valid=0 after the fourth pop.
- Queue full, in_valid=1 with y=9, and out_ready=1 in the same cycle. Required: head popped, y=9 not accepted (count=3). On the next cycle y=9 is accepted and count=4.
- Flag checks, one push each:
  - y=32'h7F800000 with ovf=1 gives fflags=100.
  - Then y=32'h7FC00000 gives 110.
  - Then y=32'h80000000 gives 111.
  - fflags_clr together with a push of y=0 gives 001.
  - fflags_clr alone gives 000.
- Wrap-around: run 10 push/pop pairs with simultaneous push and pop at count=2. Required: count stays at 2 and output order matches input order across the pointer wrap.
- Queue holding 3 entries, flush=1 together with in_valid=1, y=32'h7F800000, ovf=1. Required: count=0, out_valid=0, fflags unchanged (ovf bit not set), in_ready=1 on the next cycle.
